upower_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters: instruction fetch (IF) and load/store data (D).
- Sits between the core's fetch/PC logic and its load/store path on one side, and the memory macro on the other.
- Sequences each access through a fixed-latency memory port and returns the read data to the requester that issued it.
- Converts the core's single-cycle memory assumption into a stall-capable req/gnt/rvalid protocol.

---
 rtl/upower_arb_pkg.sv | 18 +
 rtl/upower_arb_pick.sv | 27 ++
 rtl/upower_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_upower_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/upower_arb_pkg.sv
// Shared encodings and defaults for the unified-memory arbiter.
// Pulled in by upower_arb_pick and upower_mem_arbiter.
package upower_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int MEM_LAT_DEF = 2;

endpackage

// File: rtl/upower_arb_pick.sv
// Combinational owner selection between fetch and data requesters.
// Build macro ARB_RR_EN: alternate ownership on ties; otherwise D always wins a tie.
module upower_arb_pick
    import upower_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
`ifdef ARB_RR_EN
    input  owner_t rr_last,
`endif
    output owner_t owner
);

    always_comb begin
        owner = OWN_IF;
        if (d_req) begin
            owner = OWN_D;
        end
`ifdef ARB_RR_EN
        // On a tie, hand the grant to whoever did not own the previous one.
        if (d_req && if_req) begin
            owner = (rr_last == OWN_IF) ? OWN_D : OWN_IF;
        end
`endif
    end

endmodule

// File: rtl/upower_mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one fixed-latency memory port.
// Build macro ARB_RR_EN enables round-robin tie breaking (see upower_arb_pick).
//
// state  | meaning
// IDLE   | no access in flight; a request sampled here is granted
// ACCESS | mem_en held for MEM_LAT cycles; gnt pulses in the first one
// RESP   | owner's rvalid pulses; always returns to IDLE
module upower_mem_arbiter
    import upower_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, pick_owner;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              any_req;

    assign any_req = if_req | d_req;

`ifdef ARB_RR_EN
    owner_t rr_last_q;

    upower_arb_pick u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
        .rr_last (rr_last_q),
        .owner   (pick_owner)
    );
`else
    upower_arb_pick u_pick (
        .if_req (if_req),
        .d_req  (d_req),
        .owner  (pick_owner)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            cnt_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
`ifdef ARB_RR_EN
            rr_last_q  <= OWN_IF;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= pick_owner;
                        cnt_q   <= CNT_LOAD;
`ifdef ARB_RR_EN
                        rr_last_q <= pick_owner;
`endif
                        if (pick_owner == OWN_D) begin
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
                        end else begin
                            addr_q  <= if_addr;
                            we_q    <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= mem_rdata;
                        end else begin
                            // A store acknowledge returns zero, not whatever the macro drives.
                            d_rdata_q <= we_q ? '0 : mem_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                // Counter still at its load value only in the first ACCESS cycle.
                if (cnt_q == CNT_LOAD) begin
                    if_gnt = (owner_q == OWN_IF);
                    d_gnt  = (owner_q == OWN_D);
                end
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if_rvalid = (owner_q == OWN_IF);
                d_rvalid  = (owner_q == OWN_D);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_upower_mem_arbiter.sv
// Directed bench for upower_mem_arbiter with a response scoreboard.
// Tie-order expectations follow the ARB_RR_EN build macro.
module tb_upower_mem_arbiter;
    import upower_arb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr;
    logic [63:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    logic        l1_if_req, l1_if_gnt, l1_if_rvalid, l1_d_gnt, l1_d_rvalid;
    logic [31:0] l1_if_addr, l1_mem_addr;
    logic [63:0] l1_if_rdata, l1_d_rdata, l1_mem_wdata, l1_mem_rdata;
    logic        l1_mem_en, l1_mem_we, l1_busy;

    logic [63:0] mem_arr [0:255] = '{default: 64'h0};

    assign mem_rdata    = mem_arr[mem_addr[7:0]];
    assign l1_mem_rdata = mem_arr[l1_mem_addr[7:0]];

    always @(posedge clock) begin
        if (reset) begin
            mem_arr[8'h10] <= 64'hDEAD;
            mem_arr[8'h40] <= 64'hBEEF;
        end else if (mem_en && mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wdata;
        end
    end

    upower_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(2)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    upower_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt),
        .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(64'h0),
        .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    typedef struct {
        owner_t      own;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, and retire any response.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        cyc++;
        chk("rvalid_overlap", {63'h0, if_rvalid & d_rvalid}, 64'h0);
        if (if_rvalid || d_rvalid) begin
            chk("sb_nonempty", {63'h0, sb.size() != 0}, 64'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_owner", {63'h0, d_rvalid}, {63'h0, e.own == OWN_D});
                chk("rsp_data", d_rvalid ? d_rdata : if_rdata, e.data);
            end
        end
    endtask

    owner_t tie_exp [3];
    int     ngr;
    int     rv1;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        l1_if_req = 1'b0; l1_if_addr = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_mem_en", {63'h0, mem_en}, 64'h0);
        chk("rst_gnt", {62'h0, if_gnt, d_gnt}, 64'h0);
        chk("rst_rvalid", {62'h0, if_rvalid, d_rvalid}, 64'h0);
        chk("rst_if_rdata", if_rdata, 64'h0);
        chk("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
        chk("rst_l1_busy", {63'h0, l1_busy}, 64'h0);

        // Lone fetch
        if_req = 1'b1; if_addr = 32'h10;
        sb.push_back('{OWN_IF, 64'hDEAD});
        tick();
        chk("f_if_gnt", {63'h0, if_gnt}, 64'h1);
        chk("f_d_gnt", {63'h0, d_gnt}, 64'h0);
        chk("f_mem_en1", {63'h0, mem_en}, 64'h1);
        chk("f_mem_addr1", {32'h0, mem_addr}, 64'h10);
        if_req = 1'b0; if_addr = 32'h99;
        tick();
        chk("f_mem_en2", {63'h0, mem_en}, 64'h1);
        chk("f_gnt_once", {63'h0, if_gnt}, 64'h0);
        chk("f_mem_addr2", {32'h0, mem_addr}, 64'h10);
        tick();
        chk("f_rvalid", {63'h0, if_rvalid}, 64'h1);
        chk("f_mem_en3", {63'h0, mem_en}, 64'h0);
        tick();
        chk("f_busy4", {63'h0, busy}, 64'h0);
        chk("f_rdata_hold", if_rdata, 64'hDEAD);

        // Simultaneous fetch and load
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        sb.push_back('{OWN_D, 64'hBEEF});
        sb.push_back('{OWN_IF, 64'hDEAD});
        tick();
        chk("s_d_gnt", {63'h0, d_gnt}, 64'h1);
        chk("s_if_gnt", {63'h0, if_gnt}, 64'h0);
        chk("s_mem_addr", {32'h0, mem_addr}, 64'h40);
        d_req = 1'b0;
        tick();
        tick();
        chk("s_d_rvalid", {63'h0, d_rvalid}, 64'h1);
        rv1 = cyc;
        tick();
        chk("s_idle", {63'h0, busy}, 64'h0);
        chk("s_no_b2b", {63'h0, if_gnt}, 64'h0);
        tick();
        chk("s_if_gnt2", {63'h0, if_gnt}, 64'h1);
        chk("s_mem_addr2", {32'h0, mem_addr}, 64'h10);
        if_req = 1'b0;
        for (int i = 0; i < 10 && !if_rvalid; i++) tick();
        chk("s_if_rvalid_seen", {63'h0, if_rvalid}, 64'h1);
        chk("s_rvalid_gap", 64'(cyc - rv1), 64'd4);
        tick();

        // Store, then read it back through fetch
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 64'h1234;
        sb.push_back('{OWN_D, 64'h0});
        tick();
        chk("w_d_gnt", {63'h0, d_gnt}, 64'h1);
        chk("w_mem_we1", {63'h0, mem_we}, 64'h1);
        chk("w_mem_wdata1", mem_wdata, 64'h1234);
        chk("w_mem_addr1", {32'h0, mem_addr}, 64'h20);
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 64'hFFFF;
        tick();
        chk("w_mem_we2", {63'h0, mem_we}, 64'h1);
        chk("w_mem_wdata2", mem_wdata, 64'h1234);
        tick();
        chk("w_d_rvalid", {63'h0, d_rvalid}, 64'h1);
        chk("w_mem_we3", {63'h0, mem_we}, 64'h0);
        tick();
        if_req = 1'b1; if_addr = 32'h20;
        sb.push_back('{OWN_IF, 64'h1234});
        tick();
        chk("rb_if_gnt", {63'h0, if_gnt}, 64'h1);
        if_req = 1'b0;
        tick();
        tick();
        chk("rb_if_rvalid", {63'h0, if_rvalid}, 64'h1);
        tick();

        // Request withdrawn between edges
        d_req = 1'b1;
        #2;
        d_req = 1'b0;
        tick();
        chk("wd_busy", {63'h0, busy}, 64'h0);
        chk("wd_mem_en", {63'h0, mem_en}, 64'h0);

        // Both requests held continuously
`ifdef ARB_RR_EN
        tie_exp[0] = OWN_D; tie_exp[1] = OWN_IF; tie_exp[2] = OWN_D;
`else
        tie_exp[0] = OWN_D; tie_exp[1] = OWN_D;  tie_exp[2] = OWN_D;
`endif
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{tie_exp[k], (tie_exp[k] == OWN_D) ? 64'hBEEF : 64'hDEAD});
        end
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        ngr = 0;
        for (int i = 0; i < 40 && ngr < 3; i++) begin
            tick();
            if (if_gnt || d_gnt) begin
                chk($sformatf("tie_grant%0d", ngr), {63'h0, d_gnt}, {63'h0, tie_exp[ngr] == OWN_D});
                ngr++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("tie_ngrants", 64'(ngr), 64'd3);
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("tie_drained", 64'(sb.size()), 64'd0);
        tick();
        tick();

        // Reset in the second ACCESS cycle
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        chk("r_if_gnt", {63'h0, if_gnt}, 64'h1);
        if_req = 1'b0;
        tick();
        chk("r_mem_en", {63'h0, mem_en}, 64'h1);
        reset = 1'b1;
        tick();
        chk("r_busy", {63'h0, busy}, 64'h0);
        chk("r_mem_en0", {63'h0, mem_en}, 64'h0);
        chk("r_mem_addr0", {32'h0, mem_addr}, 64'h0);
        chk("r_if_rdata0", if_rdata, 64'h0);
        chk("r_d_rdata0", d_rdata, 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("r_no_rvalid", {62'h0, if_rvalid, d_rvalid}, 64'h0);

        // MEM_LAT = 1 lone fetch
        l1_if_req = 1'b1; l1_if_addr = 32'h10;
        tick();
        chk("l1_gnt", {63'h0, l1_if_gnt}, 64'h1);
        chk("l1_mem_en1", {63'h0, l1_mem_en}, 64'h1);
        l1_if_req = 1'b0;
        tick();
        chk("l1_mem_en2", {63'h0, l1_mem_en}, 64'h0);
        chk("l1_rvalid", {63'h0, l1_if_rvalid}, 64'h1);
        chk("l1_rdata", l1_if_rdata, 64'hDEAD);
        tick();
        chk("l1_busy", {63'h0, l1_busy}, 64'h0);
        chk("l1_rvalid_once", {63'h0, l1_if_rvalid}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
